// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder with one carry flip-flop
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_sh_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             bit_sum_d;
  logic             carry_d;

  // Single full-adder cell fed by the operand LSBs and the stored carry.
  always_comb begin
    bit_sum_d = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    carry_d   = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
  end

  // Control FSM and datapath; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            // Operands are captured here, so later input changes cannot disturb the add.
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          sum_sh_q <= {bit_sum_d, sum_sh_q[WIDTH-1:1]};
          carry_q  <= carry_d;
          if (cnt_q == LAST_BIT) begin
            // Counter parks on the last bit instead of wrapping.
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          sum_q   <= sum_sh_q;
          cout_q  <= carry_q;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;

  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  int n_checks;
  int n_fail;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request; returns 1 time unit after the accepting edge with start low.
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    step();
    start8 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    step(); step();
    n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy8); end
    n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done8); end
    n_checks++; if (sum8 !== 8'h00) begin n_fail++; $display("FAIL reset_sum got=%h exp=00", sum8); end
    n_checks++; if (cout8 !== 1'b0) begin n_fail++; $display("FAIL reset_cout got=%b exp=0", cout8); end
    rst_n = 1'b1;
    step();
  endtask

  // Generic timed add with hold value checks: busy for 8 samples, done only at sample 9.
  task automatic test_add(input string nm, input logic [7:0] av, input logic [7:0] bv,
                          input logic cv, input logic [7:0] es, input logic ec,
                          input logic [7:0] hs, input logic hc);
    start_op(av, bv, cv);
    for (int i = 0; i <= 10; i++) begin
      n_checks++;
      if (busy8 !== (i < 8)) begin n_fail++; $display("FAIL %s_busy@%0d got=%b exp=%b", nm, i, busy8, (i < 8)); end
      n_checks++;
      if (done8 !== (i == 9)) begin n_fail++; $display("FAIL %s_done@%0d got=%b exp=%b", nm, i, done8, (i == 9)); end
      if (i < 9) begin
        n_checks++;
        if ({cout8, sum8} !== {hc, hs}) begin n_fail++; $display("FAIL %s_hold@%0d got=%b_%h exp=%b_%h", nm, i, cout8, sum8, hc, hs); end
      end else begin
        n_checks++;
        if ({cout8, sum8} !== {ec, es}) begin n_fail++; $display("FAIL %s_result got=%b_%h exp=%b_%h", nm, cout8, sum8, ec, es); end
      end
      if (i < 10) step();
    end
  endtask

  task automatic test_zero();
    test_add("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_full_carry();
    test_add("ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back();
    test_add("a5_5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1);
    test_add("3c_0f", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_ignore_start();
    int dones;
    dones = 0;
    start_op(8'h12, 8'h34, 1'b0);
    for (int i = 0; i <= 14; i++) begin
      if (i < 8) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      if (done8 === 1'b1) dones++;
      if (i == 9) begin
        n_checks++;
        if ({cout8, sum8} !== {1'b0, 8'h46}) begin n_fail++; $display("FAIL ignore_result got=%b_%h exp=0_46", cout8, sum8); end
      end
      if (i >= 10) begin
        n_checks++;
        if (busy8 !== 1'b0) begin n_fail++; $display("FAIL ignore_busy@%0d got=%b exp=0", i, busy8); end
      end
      step();
    end
    n_checks++;
    if (dones !== 1) begin n_fail++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    start_op(8'h11, 8'h22, 1'b0);
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy8); end
    n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL midrst_done got=%b exp=0", done8); end
    n_checks++; if (sum8 !== 8'h00) begin n_fail++; $display("FAIL midrst_sum got=%h exp=00", sum8); end
    n_checks++; if (cout8 !== 1'b0) begin n_fail++; $display("FAIL midrst_cout got=%b exp=0", cout8); end
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (done8 === 1'b1 || busy8 === 1'b1) dones++;
      step();
    end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL midrst_activity got=%0d exp=0", dones); end
    test_add("post_rst", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
  endtask

  task automatic test_exhaustive4();
    logic [8:0] n;
    logic [4:0] exp;
    n = 9'd0;
    a4 = n[3:0]; b4 = n[7:4]; cin4 = n[8]; start4 = 1'b1;
    step();
    for (int k = 0; k < 512; k++) begin
      exp = {1'b0, a4} + {1'b0, b4} + {4'b0, cin4};
      n = 9'(k + 1);
      a4 = n[3:0]; b4 = n[7:4]; cin4 = n[8];
      if (k == 511) start4 = 1'b0;
      step(); step(); step(); step();
      n_checks++;
      if (done4 !== 1'b0) begin n_fail++; $display("FAIL w4_early_done k=%0d got=%b exp=0", k, done4); end
      step();
      n_checks++;
      if (done4 !== 1'b1) begin n_fail++; $display("FAIL w4_done k=%0d got=%b exp=1", k, done4); end
      n_checks++;
      if ({cout4, sum4} !== exp) begin n_fail++; $display("FAIL w4_sum k=%0d got=%h exp=%h", k, {cout4, sum4}, exp); end
      step();
    end
  endtask

  // Test sequence.
  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_zero();
    test_full_carry();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_exhaustive4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
